// File: rtl/otf_pkg.sv
// otf_pkg: shared FSM state, signed-digit encodings and default sizes
package otf_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, CONV, DONE} state_t;
  localparam logic [1:0] SD_POS = 2'b10;
  localparam logic [1:0] SD_NEG = 2'b01;
  localparam int N_DEF = 16;
  localparam int DELAY_DEF = 2;
endpackage

// File: rtl/otf_converter_step.sv
// otf_step: one on-the-fly conversion step of the Q/QM register pair
module otf_step
  import otf_pkg::*;
#(
  parameter int W = N_DEF + 1
) (
  input  logic [1:0]   digit,
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);
  logic pos, neg;
  // select shift source and appended bit from the decoded digit; 11 falls through as zero
  always_comb begin
    pos    = digit == SD_POS;
    neg    = digit == SD_NEG;
    q_nxt  = pos ? W'({q, 1'b1}) : neg ? W'({qm, 1'b1}) : W'({q, 1'b0});
    qm_nxt = pos ? W'({q, 1'b0}) : neg ? W'({qm, 1'b0}) : W'({qm, 1'b1});
  end
endmodule

// File: rtl/otf_converter.sv
// otf_converter: radix-2 signed-digit stream to two's-complement on-the-fly converter
module otf_converter
  import otf_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DELAY = DELAY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [1:0] z,
  output logic [N:0] result,
  output logic       done,
  output logic       busy
);
  localparam int CW = ($clog2(N + 1) > 0) ? $clog2(N + 1) : 1;
  localparam int SW = ($clog2(DELAY + 1) > 0) ? $clog2(DELAY + 1) : 1;
  state_t state, state_n;
  logic [N:0] q, qm, q_n, qm_n;
  logic [SW-1:0] cnt_skip;
  logic [CW-1:0] cnt_dig;
  logic skip_last, dig_last;
  assign skip_last = int'(cnt_skip) == DELAY - 1;
  assign dig_last  = int'(cnt_dig) == N - 1;
  assign done      = state == DONE;
  assign busy      = state == SKIP || state == CONV;
  otf_step #(.W(N + 1)) u_step (
    .digit (z),
    .q     (q),
    .qm    (qm),
    .q_nxt (q_n),
    .qm_nxt(qm_n)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state: stalls hold SKIP/CONV, DONE always returns to IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ((DELAY > 0) ? SKIP : CONV) : IDLE;
      SKIP:    state_n = (enable && skip_last) ? CONV : SKIP;
      CONV:    state_n = (enable && dig_last) ? DONE : CONV;
      default: state_n = IDLE;
    endcase
  end
  // datapath: Q/QM, counters and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      qm       <= '1;
      cnt_skip <= '0;
      cnt_dig  <= '0;
      result   <= '0;
    end else if (state == IDLE && start) begin
      q        <= '0;
      qm       <= '1;
      cnt_skip <= '0;
      cnt_dig  <= '0;
    end else if (state == SKIP && enable) begin
      cnt_skip <= cnt_skip + 1'b1;
    end else if (state == CONV && enable) begin
      q       <= q_n;
      qm      <= qm_n;
      cnt_dig <= cnt_dig + 1'b1;
      if (dig_last) result <= q_n;
    end
  end
endmodule

// File: tb/tb_otf_converter.sv
// tb_otf_converter: scoreboard bench for otf_converter with N=4, DELAY=2
module tb_otf_converter;
  localparam int N = 4;
  localparam int DELAY = 2;
  logic clk = 0;
  logic rst, start, enable;
  logic [1:0] z;
  logic [N:0] result;
  logic done, busy;
  int n_cmp = 0, n_err = 0, n_done = 0, n_starts = 0;
  logic [N:0] sb[$];

  otf_converter #(.N(N), .DELAY(DELAY)) dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .z(z),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dval(input logic [1:0] d);
    return d == 2'b10 ? 1 : d == 2'b01 ? -1 : 0;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) check("done_without_start", int'(done), 0);
      else check("result", int'(result), int'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input logic [1:0] d0, d1, d2, d3, input int st_at, input int st_len,
                      input bit spur, output int exp_v);
    logic [1:0] dig[4];
    logic [N:0] e;
    dig = '{d0, d1, d2, d3};
    exp_v = 0;
    for (int i = 0; i < N; i++) exp_v = exp_v * 2 + dval(dig[i]);
    e = exp_v[N:0];
    sb.push_back(e);
    n_starts++;
    start = 1; enable = 1; z = 2'($urandom);
    tick();
    start = 0;
    for (int j = 0; j < DELAY; j++) begin
      check("busy_skip", int'(busy), 1);
      z = 2'($urandom);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      if (i == st_at)
        for (int s = 0; s < st_len; s++) begin
          enable = 0; z = 2'($urandom);
          tick();
          check("stall_busy", int'(busy), 1);
          check("stall_done", int'(done), 0);
        end
      enable = 1;
      start = spur && i == 1;
      check("done_early", int'(done), 0);
      z = dig[i];
      tick();
      start = 0;
    end
    check("done_on_time", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    start = spur;
    tick();
    start = 0;
    check("done_single", int'(done), 0);
    check("start_in_done_ignored", int'(busy), 0);
    tick();
    check("idle_busy", int'(busy), 0);
  endtask

  int v;

  initial begin
    rst = 1; start = 0; enable = 0; z = 0;
    tick(); tick();
    check("rst_result", int'(result), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    rst = 0;
    tick();
    conv(2'b10, 2'b00, 2'b01, 2'b10, -1, 0, 0, v);
    check("exp_7", v, 7);
    repeat (3) tick();
    check("result_hold", int'(result), 7);
    conv(2'b01, 2'b01, 2'b01, 2'b01, -1, 0, 0, v);
    conv(2'b10, 2'b10, 2'b10, 2'b10, -1, 0, 0, v);
    conv(2'b11, 2'b10, 2'b11, 2'b01, -1, 0, 0, v);
    conv(2'b10, 2'b00, 2'b01, 2'b10, 2, 3, 0, v);
    conv(2'b10, 2'b10, 2'b00, 2'b01, -1, 0, 1, v);
    conv(2'b01, 2'b10, 2'b00, 2'b10, 1, 2, 1, v);
    start = 1; enable = 1; z = 2'b00;
    tick();
    start = 0;
    for (int j = 0; j < DELAY; j++) tick();
    z = 2'b10; tick();
    z = 2'b01; tick();
    rst = 1; start = 1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_done", int'(done), 0);
    rst = 0; start = 0;
    repeat (6) begin
      tick();
      check("abort_no_done", int'(done), 0);
    end
    conv(2'b10, 2'b00, 2'b01, 2'b10, -1, 0, 0, v);
    repeat (2) tick();
    check("done_count", n_done, n_starts);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
